// File: rtl/dp_inst_loader_pkg.sv
// Shared definitions for the DP instruction loader: store geometry, format
// codes, reject codes, FSM states and the decoded field bundle.
package dp_inst_loader_pkg;

  localparam int DP_AW    = 6;
  localparam int DP_DEPTH = 1 << DP_AW;

  localparam logic [1:0] FMT_DP0 = 2'd0;  // immediate shift
  localparam logic [1:0] FMT_DP1 = 2'd1;  // register shift
  localparam logic [1:0] FMT_DP2 = 2'd2;  // rotated immediate
  localparam logic [1:0] FMT_ILL = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RD_PC   = 2'd1;
  localparam logic [1:0] ERR_FMT     = 2'd2;
  localparam logic [1:0] ERR_CMP_NOS = 2'd3;

  // Compare-class opcodes (TST/TEQ/CMP/CMN) are 4'b10xx.
  localparam logic [1:0] CMP_OP_HI = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] op;
    logic       s_bit;
    logic [1:0] fmt;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic [3:0] rs;
    logic [1:0] shift_type;
    logic [4:0] shift_imm;
    logic [3:0] rot;
    logic [7:0] imm8;
  } dp_req_t;

  function automatic logic is_cmp_op(input logic [3:0] op);
    return op[3:2] == CMP_OP_HI;
  endfunction

endpackage

// File: rtl/dp_inst_loader_if.sv
// Loader bus: field-bundle handshake, store control, CPU fetch port and status.
interface dp_inst_loader_if;
  import dp_inst_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  dp_req_t           req;
  logic              clear;
  logic [DP_AW-1:0]  inst_addr;
  logic [31:0]       inst_word;
  logic [DP_AW:0]    wr_count;
  logic              full;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output in_valid, req, clear, inst_addr,
    input  in_ready, inst_word, wr_count, full, err, err_code
  );

  modport slave (
    input  in_valid, req, clear, inst_addr,
    output in_ready, inst_word, wr_count, full, err, err_code
  );
endinterface

// File: rtl/dp_inst_loader_encode.sv
// Combinational encoder: decoded DP fields -> 32-bit machine word plus the
// highest-priority undefined-instruction code (ERR_NONE when legal).
module dp_inst_encode
  import dp_inst_loader_pkg::*;
(
  input  dp_req_t     req_i,
  output logic [31:0] word_o,
  output logic [1:0]  code_o
);

  // Assemble the word for the selected format; illegal format encodes as zero.
  always_comb begin
    word_o = '0;
    unique case (req_i.fmt)
      FMT_DP0: word_o = {req_i.cond, 3'b000, req_i.op, req_i.s_bit, req_i.rn, req_i.rd,
                         req_i.shift_imm, req_i.shift_type, 1'b0, req_i.rm};
      FMT_DP1: word_o = {req_i.cond, 3'b000, req_i.op, req_i.s_bit, req_i.rn, req_i.rd,
                         req_i.rs, 1'b0, req_i.shift_type, 1'b1, req_i.rm};
      FMT_DP2: word_o = {req_i.cond, 3'b001, req_i.op, req_i.s_bit, req_i.rn, req_i.rd,
                         req_i.rot, req_i.imm8};
      default: word_o = '0;
    endcase
  end

  // Rule check in priority order: PC destination, bad format, compare without S.
  always_comb begin
    code_o = ERR_NONE;
    if (req_i.rd == 4'hF)                              code_o = ERR_RD_PC;
    else if (req_i.fmt == FMT_ILL)                     code_o = ERR_FMT;
    else if (is_cmp_op(req_i.op) && !req_i.s_bit)      code_o = ERR_CMP_NOS;
  end

endmodule

// File: rtl/dp_inst_loader.sv
// Instruction loader: accepts field bundles, encodes and checks them, and
// appends legal words to a 64-word store read asynchronously by the CPU.
module dp_inst_loader
  import dp_inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dp_inst_loader_if.slave   bus
);

  ld_state_e       state_q, state_d;
  dp_req_t         req_q;
  logic [DP_AW:0]  wr_count_q, wr_count_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     mem_q [DP_DEPTH];

  logic [31:0]     enc_word;
  logic [1:0]      enc_code;
  logic            full;
  logic            in_ready;
  logic            err;
  logic            wr_en;
  logic            hs;

  dp_inst_encode u_enc (
    .req_i  (req_q),
    .word_o (enc_word),
    .code_o (enc_code)
  );

  assign full = (wr_count_q == (DP_AW+1)'(DP_DEPTH));
  assign hs   = bus.in_valid & in_ready;

  // Next-state and per-state outputs; clear only takes effect while idle and
  // blocks acceptance in that same cycle.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    err_code_d = err_code_q;
    in_ready   = 1'b0;
    err        = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = !full && !bus.clear;
        if (bus.clear)  wr_count_d = '0;
        else if (hs)    state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        // Code is latched here so it is already visible during the err pulse.
        if (enc_code != ERR_NONE) begin
          state_d    = ST_ERR;
          err_code_d = enc_code;
        end else begin
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        wr_count_d = wr_count_q + (DP_AW+1)'(1);
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer and reject-code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      err_code_q <= err_code_d;
    end
  end

  // Capture the bundle on handshake; it stays stable through CHECK/WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      req_q <= '0;
    else if (hs)  req_q <= bus.req;
  end

  // Instruction store; reset clears every word so fetches of unwritten slots read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DP_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_count_q[DP_AW-1:0]] <= enc_word;
    end
  end

  assign bus.inst_word = mem_q[bus.inst_addr];
  assign bus.in_ready  = in_ready;
  assign bus.wr_count  = wr_count_q;
  assign bus.full      = full;
  assign bus.err       = err;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_dp_inst_loader.sv
// Bench for dp_inst_loader: directed encodings and rejects, random fill to
// full, clear, and reset during a write, against a queue/array model.
module tb_dp_inst_loader;
  import dp_inst_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dp_inst_loader_if bus ();
  dp_inst_loader dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_mem [64];
  int          exp_cnt;
  logic [1:0]  exp_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encoding built from field weights.
  function automatic logic [31:0] model_word(input dp_req_t r);
    int unsigned w;
    w = r.cond * 2**28 + r.op * 2**21 + r.s_bit * 2**20 + r.rn * 2**16 + r.rd * 2**12;
    case (r.fmt)
      2'd0: w += r.shift_imm * 128 + r.shift_type * 32 + r.rm;
      2'd1: w += r.rs * 256 + r.shift_type * 32 + 16 + r.rm;
      2'd2: w += 2**25 + r.rot * 256 + r.imm8;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic logic [1:0] model_code(input dp_req_t r);
    if (r.rd == 15)                              return 2'd1;
    if (r.fmt == 3)                              return 2'd2;
    if (r.op >= 8 && r.op <= 11 && r.s_bit == 0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic dp_req_t mk(input int cond, op, s, fmt, rn, rd, rm, rs, st, si, rot, imm);
    dp_req_t r;
    r.cond = 4'(cond); r.op = 4'(op); r.s_bit = 1'(s); r.fmt = 2'(fmt);
    r.rn = 4'(rn); r.rd = 4'(rd); r.rm = 4'(rm); r.rs = 4'(rs);
    r.shift_type = 2'(st); r.shift_imm = 5'(si); r.rot = 4'(rot); r.imm8 = 8'(imm);
    return r;
  endfunction

  function automatic dp_req_t rand_req();
    dp_req_t r;
    r = mk($urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom, $urandom_range(0, 14),
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    if (r.op >= 8 && r.op <= 11) r.s_bit = 1'b1;
    case ($urandom_range(0, 9))
      0: r.rd = 4'hF;
      1: r.fmt = 2'd3;
      2: begin r.op = 4'(8 + $urandom_range(0, 3)); r.s_bit = 1'b0; end
      default: ;
    endcase
    return r;
  endfunction

  // One bundle through handshake, CHECK, WRITE/ERR and back to IDLE, checking each cycle.
  // clr_mid raises clear during CHECK/WRITE, where it must have no effect.
  task automatic send(input dp_req_t r, input bit clr_mid);
    int         waitc = 0;
    logic [1:0] code;
    logic [5:0] addr;
    @(negedge clk);
    bus.req = r; bus.in_valid = 1'b1;
    while (!bus.in_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!bus.in_ready) begin
      chk("hs_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.req = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    if (clr_mid) bus.clear = 1'b1;
    code = model_code(r);
    addr = exp_cnt[5:0];
    bus.inst_addr = addr;
    @(negedge clk);
    chk("ready_check", bus.in_ready, 0);
    chk("err_check", bus.err, 0);
    @(negedge clk);
    chk("err_pulse", bus.err, (code != 0));
    chk("ready_wr", bus.in_ready, 0);
    if (code != 0) chk("err_code", bus.err_code, code);
    else           chk("rd_old", bus.inst_word, exp_mem[addr]);
    if (code == 0) begin exp_mem[addr] = model_word(r); exp_cnt++; end
    else           exp_code = code;
    bus.clear = 1'b0;
    @(negedge clk);
    chk("err_low", bus.err, 0);
    chk("wr_count", bus.wr_count, exp_cnt);
    chk("full", bus.full, (exp_cnt == 64));
    chk("err_code_hold", bus.err_code, exp_code);
    chk("rd_new", bus.inst_word, exp_mem[addr]);
    chk("ready_idle", bus.in_ready, (exp_cnt != 64));
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    bus.inst_addr = 6'(addr);
    #1;
    chk(tag, bus.inst_word, exp);
  endtask

  task automatic dump_chk(input string tag);
    for (int i = 0; i < 64; i++) rd_chk(tag, i, exp_mem[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    exp_cnt = 0; exp_code = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dp_req_t r;
    int      iters;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.inst_addr = '0;
    bus.req = '0;
    model_reset();
    rst = 1'b1;
    #12;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_count", bus.wr_count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_code", bus.err_code, 0);
    @(negedge clk); rst = 1'b0;
    dump_chk("rst_mem");

    // Directed encodings.
    send(mk(14, 4, 0, 0, 2, 1, 3, 0, 0, 2, 0, 0), 1'b0);
    rd_chk("dp0_word", 0, 32'hE0821103);
    send(mk(14, 2, 1, 1, 5, 4, 6, 7, 1, 0, 0, 0), 1'b1);
    rd_chk("dp1_word", 1, 32'hE0554736);
    send(mk(14, 13, 0, 2, 0, 0, 0, 0, 0, 0, 4, 255), 1'b0);
    rd_chk("dp2_word", 2, 32'hE3A004FF);

    // Rejects in each priority class.
    send(mk(14, 4, 0, 3, 0, 15, 0, 0, 0, 0, 0, 0), 1'b0);
    send(mk(14, 4, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    send(mk(14, 10, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0), 1'b0);
    rd_chk("rej_untouched", 3, 32'h0);

    // Random fill to full.
    iters = 0;
    while (exp_cnt < 64 && iters < 400) begin
      send(rand_req(), ($urandom_range(0, 7) == 0));
      iters++;
    end
    chk("fill_full", bus.full, 1);
    chk("fill_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.req = mk(14, 4, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0); bus.in_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("held_off_count", bus.wr_count, 64);
    chk("held_off_ready", bus.in_ready, 0);
    dump_chk("full_mem");

    // Clear collides with a valid bundle: clear wins, nothing accepted.
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b1;
    bus.req = mk(1, 4, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0);
    #1 chk("clear_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("clear_count", bus.wr_count, 0);
    chk("clear_full", bus.full, 0);
    chk("clear_ready_idle", bus.in_ready, 1);
    repeat (3) @(negedge clk);
    chk("clear_no_accept", bus.wr_count, 0);
    send(mk(3, 12, 1, 2, 7, 8, 0, 0, 0, 0, 9, 8'h5A), 1'b0);
    rd_chk("clear_keep", 1, exp_mem[1]);

    // Reset in WRITE: no write lands, everything returns to reset values.
    @(negedge clk);
    bus.req = mk(14, 4, 0, 0, 2, 1, 3, 0, 0, 2, 0, 0); bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rstw_count", bus.wr_count, 0);
    chk("rstw_full", bus.full, 0);
    chk("rstw_err", bus.err, 0);
    chk("rstw_code", bus.err_code, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstw_ready", bus.in_ready, 1);
    chk("rstw_count2", bus.wr_count, 0);
    dump_chk("rstw_mem");
    send(mk(14, 13, 1, 2, 0, 3, 0, 0, 0, 0, 1, 8'h81), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
